// File: rtl/fp_norm_round_seq_pkg.sv
// Shared definitions for the fp_norm_round_seq normalise/round stage:
// FP field widths, significand bit positions, FSM state encoding and
// the round-to-nearest-even decision helper.
package fp_norm_round_seq_pkg;

    localparam int MANT_W = 23;
    localparam int EXP_W  = 8;
    localparam int SIG_W  = MANT_W + 5;

    localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};

    // Significand layout: {OVF, HID, fraction[MANT_W-1:0], G, R, S}
    localparam int OVF_IDX  = SIG_W - 1;
    localparam int HID_IDX  = SIG_W - 2;
    localparam int FRAC_LSB = 3;
    localparam int G_IDX    = 2;
    localparam int R_IDX    = 1;
    localparam int S_IDX    = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_NORM  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Round-to-nearest-even: increment when above half, or exactly half with odd LSB
    function automatic logic round_up(input logic g, input logic r,
                                      input logic s, input logic lsb);
        return g & (r | s | lsb);
    endfunction

endpackage

// File: rtl/fp_norm_round_seq_add1.sv
// add1: ripple incrementer. oRes = iY + iCarry over nBit+1 bits,
// oCarry is the carry out of the most significant bit.
module add1 #(
    parameter int nBit = 22
) (
    input  logic [nBit:0] iY,
    input  logic          iCarry,
    output logic [nBit:0] oRes,
    output logic          oCarry
);

    // Ripple the increment carry from the LSB upward
    always_comb begin
        logic c_v;
        c_v  = iCarry;
        oRes = {(nBit+1){1'b0}};
        for (int i = 0; i <= nBit; i++) begin
            oRes[i] = iY[i] ^ c_v;
            c_v     = iY[i] & c_v;
        end
        oCarry = c_v;
    end

endmodule

// File: rtl/fp_norm_round_seq.sv
// fp_norm_round_seq: sequential normalise-and-round stage for
// single-precision results. Normalises one shift per cycle, rounds to
// nearest even through the add1 incrementer, and hands the packed result
// downstream with a valid/ready handshake.
// Optional status flags (oInexact/oOverflow/oUnderflow) are built when
// the macro FPN_FLAGS_EN is defined.
module fp_norm_round_seq
    import fp_norm_round_seq_pkg::*;
#(
    parameter int MANT_W = fp_norm_round_seq_pkg::MANT_W,
    parameter int EXP_W  = fp_norm_round_seq_pkg::EXP_W
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iValid,
    output logic              oReady,
    input  logic              iSign,
    input  logic [EXP_W-1:0]  iExp,
    input  logic [MANT_W+4:0] iMant,
    output logic              oValid,
    input  logic              iReady,
    output logic              oSign,
    output logic [EXP_W-1:0]  oExp,
    output logic [MANT_W-1:0] oMant
`ifdef FPN_FLAGS_EN
    ,
    output logic              oInexact,
    output logic              oOverflow,
    output logic              oUnderflow
`endif
);

    localparam int SIG_WL = MANT_W + 5;
    localparam int OVF_B  = SIG_WL - 1;
    localparam int HID_B  = SIG_WL - 2;

    localparam logic [EXP_W-1:0]  EXP_ZERO = {EXP_W{1'b0}};
    localparam logic [EXP_W-1:0]  EXP_ONE  = {{(EXP_W-1){1'b0}}, 1'b1};
    localparam logic [EXP_W-1:0]  EXP_ALL1 = {EXP_W{1'b1}};
    localparam logic [SIG_WL-1:0] SIG_ZERO = {SIG_WL{1'b0}};
    localparam logic [MANT_W-1:0] MAN_ZERO = {MANT_W{1'b0}};

    state_e              state_q, state_d;
    logic                sign_q, sign_d;
    logic [EXP_W-1:0]    exp_q, exp_d;
    logic [SIG_WL-1:0]   sig_q, sig_d;

    logic                valid_q;
    logic                ready_q;
    logic                osign_q;
    logic [EXP_W-1:0]    oexp_q;
    logic [MANT_W-1:0]   omant_q;

`ifdef FPN_FLAGS_EN
    logic                inexact_q, inexact_d;
    logic                oinexact_q, ooverflow_q, ounderflow_q;
`endif

    logic [MANT_W-1:0]   frac_s;
    logic                rnd_carry_s;
    logic [MANT_W-1:0]   rnd_res_s;
    logic                rnd_cout_s;
    logic                exp_gt1_s;
    logic [EXP_W-1:0]    exp_inc_s;

    assign frac_s      = sig_q[FRAC_LSB +: MANT_W];
    assign rnd_carry_s = round_up(sig_q[G_IDX], sig_q[R_IDX], sig_q[S_IDX], sig_q[FRAC_LSB]);
    assign exp_gt1_s   = (exp_q > EXP_ONE);
    // Increment never wraps past all-ones; all-ones already means infinity
    assign exp_inc_s   = (exp_q == EXP_ALL1) ? EXP_ALL1 : (exp_q + EXP_ONE);

    add1 #(
        .nBit (MANT_W - 1)
    ) u_add1 (
        .iY     (frac_s),
        .iCarry (rnd_carry_s),
        .oRes   (rnd_res_s),
        .oCarry (rnd_cout_s)
    );

    // State register
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decision
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (iValid) begin
                    state_d = ST_NORM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_NORM: begin
                if (sig_q[OVF_B]) begin
                    state_d = ST_NORM;
                end else if (sig_q == SIG_ZERO) begin
                    state_d = ST_DONE;
                end else if (!sig_q[HID_B] && exp_gt1_s) begin
                    state_d = ST_NORM;
                end else begin
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (valid_q && iReady) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Working operand update: capture, normalise shift, round
    always_comb begin
        sign_d = sign_q;
        exp_d  = exp_q;
        sig_d  = sig_q;
`ifdef FPN_FLAGS_EN
        inexact_d = inexact_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (iValid) begin
                    sign_d = iSign;
                    exp_d  = iExp;
                    sig_d  = iMant;
`ifdef FPN_FLAGS_EN
                    inexact_d = 1'b0;
`endif
                end else begin
                    sig_d = sig_q;
                end
            end
            ST_NORM: begin
                if (sig_q[OVF_B]) begin
                    // Right shift; the bit falling off stays sticky in S
                    sig_d = {1'b0, sig_q[SIG_WL-1:2], sig_q[1] | sig_q[0]};
                    exp_d = exp_inc_s;
                end else if (sig_q == SIG_ZERO) begin
                    exp_d = EXP_ZERO;
                end else if (!sig_q[HID_B] && exp_gt1_s) begin
                    sig_d = {sig_q[SIG_WL-2:0], 1'b0};
                    exp_d = exp_q - EXP_ONE;
                end else if (!sig_q[HID_B]) begin
                    // Cannot shift further: result is denormal
                    exp_d = EXP_ZERO;
                end else begin
                    exp_d = exp_q;
                end
            end
            ST_ROUND: begin
                sig_d[FRAC_LSB +: MANT_W] = rnd_res_s;
                // Carry out of the fraction bumps the exponent; a denormal
                // going 0 -> 1 is the same increment
                if (rnd_cout_s) begin
                    exp_d = exp_inc_s;
                end else begin
                    exp_d = exp_q;
                end
`ifdef FPN_FLAGS_EN
                inexact_d = sig_q[G_IDX] | sig_q[R_IDX] | sig_q[S_IDX];
`endif
            end
            ST_DONE: begin
                sig_d = sig_q;
            end
            default: begin
                sig_d = sig_q;
            end
        endcase
    end

    // Working operand registers
    always_ff @(posedge iClk) begin
        if (iRst) begin
            sign_q <= 1'b0;
            exp_q  <= EXP_ZERO;
            sig_q  <= SIG_ZERO;
`ifdef FPN_FLAGS_EN
            inexact_q <= 1'b0;
`endif
        end else begin
            sign_q <= sign_d;
            exp_q  <= exp_d;
            sig_q  <= sig_d;
`ifdef FPN_FLAGS_EN
            inexact_q <= inexact_d;
`endif
        end
    end

    // Registered handshake and result outputs; result frozen while valid
    always_ff @(posedge iClk) begin
        if (iRst) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            osign_q <= 1'b0;
            oexp_q  <= EXP_ZERO;
            omant_q <= MAN_ZERO;
`ifdef FPN_FLAGS_EN
            oinexact_q   <= 1'b0;
            ooverflow_q  <= 1'b0;
            ounderflow_q <= 1'b0;
`endif
        end else begin
            ready_q <= (state_d == ST_IDLE);
            if ((state_q == ST_DONE) && !valid_q) begin
                valid_q <= 1'b1;
                osign_q <= sign_q;
                oexp_q  <= exp_q;
                omant_q <= (exp_q == EXP_ALL1) ? MAN_ZERO : frac_s;
`ifdef FPN_FLAGS_EN
                oinexact_q   <= inexact_q;
                ooverflow_q  <= (exp_q == EXP_ALL1);
                ounderflow_q <= (exp_q == EXP_ZERO) && inexact_q;
`endif
            end else if (valid_q && iReady) begin
                valid_q <= 1'b0;
            end else begin
                valid_q <= valid_q;
            end
        end
    end

    assign oReady = ready_q;
    assign oValid = valid_q;
    assign oSign  = osign_q;
    assign oExp   = oexp_q;
    assign oMant  = omant_q;
`ifdef FPN_FLAGS_EN
    assign oInexact   = oinexact_q;
    assign oOverflow  = ooverflow_q;
    assign oUnderflow = ounderflow_q;
`endif

endmodule

// File: tb/tb_fp_norm_round_seq.sv
// Directed, table-driven bench for fp_norm_round_seq plus hand-written
// sequences for back-pressure, busy-time input pulses and mid-operation reset.
module tb_fp_norm_round_seq;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iValid;
    logic        oReady;
    logic        iSign;
    logic [7:0]  iExp;
    logic [27:0] iMant;
    logic        oValid;
    logic        iReady;
    logic        oSign;
    logic [7:0]  oExp;
    logic [22:0] oMant;
`ifdef FPN_FLAGS_EN
    logic        oInexact, oOverflow, oUnderflow;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [7:0]  e_i;
        logic [27:0] m_i;
        logic        s;
        logic [7:0]  e_o;
        logic [22:0] m_o;
        int          lat;
        logic        ix;
        logic        ov;
        logic        un;
    } vec_t;

    vec_t vecs[16];

    fp_norm_round_seq dut (
        .iClk   (iClk),
        .iRst   (iRst),
        .iValid (iValid),
        .oReady (oReady),
        .iSign  (iSign),
        .iExp   (iExp),
        .iMant  (iMant),
        .oValid (oValid),
        .iReady (iReady),
        .oSign  (oSign),
        .oExp   (oExp),
        .oMant  (oMant)
`ifdef FPN_FLAGS_EN
        ,
        .oInexact   (oInexact),
        .oOverflow  (oOverflow),
        .oUnderflow (oUnderflow)
`endif
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        @(negedge iClk);
        iValid = 1'b1;
        iSign  = v.s;
        iExp   = v.e_i;
        iMant  = v.m_i;
        @(posedge iClk);
        #1;
        iValid = 1'b0;
        lat = 0;
        while (!oValid && lat < 40) begin
            @(posedge iClk);
            #1;
            lat++;
        end
        chk($sformatf("v%0d latency", idx), lat, v.lat);
        chk($sformatf("v%0d sign", idx), {31'd0, oSign}, {31'd0, v.s});
        chk($sformatf("v%0d exp", idx), {24'd0, oExp}, {24'd0, v.e_o});
        chk($sformatf("v%0d mant", idx), {9'd0, oMant}, {9'd0, v.m_o});
        chk($sformatf("v%0d busy_ready", idx), {31'd0, oReady}, 32'd0);
`ifdef FPN_FLAGS_EN
        chk($sformatf("v%0d inexact", idx), {31'd0, oInexact}, {31'd0, v.ix});
        chk($sformatf("v%0d overflow", idx), {31'd0, oOverflow}, {31'd0, v.ov});
        chk($sformatf("v%0d underflow", idx), {31'd0, oUnderflow}, {31'd0, v.un});
`endif
        @(negedge iClk);
        iReady = 1'b1;
        @(posedge iClk);
        #1;
        iReady = 1'b0;
        chk($sformatf("v%0d valid_drop", idx), {31'd0, oValid}, 32'd0);
        chk($sformatf("v%0d ready_back", idx), {31'd0, oReady}, 32'd1);
    endtask

    initial begin
        //            e_i     m_i            s     e_o     m_o          lat ix    ov    un
        vecs[0]  = '{8'd127, 28'h4000000, 1'b1, 8'd127, 23'h000000, 3, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{8'd127, 28'h8000000, 1'b0, 8'd128, 23'h000000, 4, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{8'd127, 28'h8000008, 1'b1, 8'd128, 23'h000000, 4, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{8'd127, 28'h8000009, 1'b0, 8'd128, 23'h000001, 4, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{8'd127, 28'h0400000, 1'b0, 8'd123, 23'h000000, 7, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{8'd2,   28'h0400000, 1'b1, 8'd0,   23'h100000, 4, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{8'd127, 28'h7FFFFFC, 1'b0, 8'd128, 23'h000000, 3, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{8'd127, 28'h4000004, 1'b0, 8'd127, 23'h000000, 3, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{8'd254, 28'h7FFFFFC, 1'b1, 8'd255, 23'h000000, 3, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{8'd50,  28'h0000000, 1'b1, 8'd0,   23'h000000, 2, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{8'd1,   28'h000000C, 1'b0, 8'd0,   23'h000002, 3, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{8'd1,   28'h3FFFFFC, 1'b0, 8'd1,   23'h000000, 3, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{8'd127, 28'h400000C, 1'b0, 8'd127, 23'h000002, 3, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{8'd127, 28'h4000003, 1'b1, 8'd127, 23'h000000, 3, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{8'd254, 28'h8000000, 1'b0, 8'd255, 23'h000000, 4, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{8'd127, 28'h0010000, 1'b0, 8'd117, 23'h000000, 13, 1'b0, 1'b0, 1'b0};

        iRst   = 1'b1;
        iValid = 1'b0;
        iReady = 1'b0;
        iSign  = 1'b0;
        iExp   = 8'd0;
        iMant  = 28'd0;
        repeat (3) @(posedge iClk);
        #1;
        chk("rst oValid", {31'd0, oValid}, 32'd0);
        chk("rst oReady", {31'd0, oReady}, 32'd1);
        chk("rst oSign", {31'd0, oSign}, 32'd0);
        chk("rst oExp", {24'd0, oExp}, 32'd0);
        chk("rst oMant", {9'd0, oMant}, 32'd0);
        @(negedge iClk);
        iRst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            run_vec(i, vecs[i]);
        end

        // Back-pressure: result held for 5 cycles while busy-time pulses arrive
        begin
            int lat;
            @(negedge iClk);
            iValid = 1'b1; iSign = 1'b1; iExp = 8'd100; iMant = 28'h4000000;
            @(posedge iClk);
            #1;
            iValid = 1'b0;
            lat = 0;
            while (!oValid && lat < 40) begin
                @(posedge iClk);
                #1;
                lat++;
            end
            chk("hold latency", lat, 3);
            for (int k = 0; k < 5; k++) begin
                @(negedge iClk);
                iValid = 1'b1; iSign = 1'b0; iExp = 8'd10 + 8'(k); iMant = 28'h8000000;
                @(posedge iClk);
                #1;
                chk($sformatf("hold%0d oValid", k), {31'd0, oValid}, 32'd1);
                chk($sformatf("hold%0d oReady", k), {31'd0, oReady}, 32'd0);
                chk($sformatf("hold%0d oExp", k), {24'd0, oExp}, 32'd100);
                chk($sformatf("hold%0d oSign", k), {31'd0, oSign}, 32'd1);
            end
            @(negedge iClk);
            iValid = 1'b0;
            iReady = 1'b1;
            @(posedge iClk);
            #1;
            iReady = 1'b0;
            chk("hold release oValid", {31'd0, oValid}, 32'd0);
            repeat (8) @(posedge iClk);
            #1;
            chk("ignored pulses oValid", {31'd0, oValid}, 32'd0);
            chk("ignored pulses oReady", {31'd0, oReady}, 32'd1);
        end

        // Reset during NORM of a 10-shift operand discards it
        @(negedge iClk);
        iValid = 1'b1; iSign = 1'b1; iExp = 8'd127; iMant = 28'h0010000;
        @(posedge iClk);
        #1;
        iValid = 1'b0;
        repeat (3) @(posedge iClk);
        @(negedge iClk);
        iRst = 1'b1;
        @(posedge iClk);
        #1;
        chk("midrst oValid", {31'd0, oValid}, 32'd0);
        chk("midrst oReady", {31'd0, oReady}, 32'd1);
        chk("midrst oExp", {24'd0, oExp}, 32'd0);
        @(negedge iClk);
        iRst = 1'b0;
        repeat (20) @(posedge iClk);
        #1;
        chk("midrst no result", {31'd0, oValid}, 32'd0);
        run_vec(100, vecs[0]);
        run_vec(101, vecs[3]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
